stat_display: RTL and testbench

- Answers the debug-selection interface driven by the board switches.
- Maintains CPU run statistics (cycles, branches, taken branches), selects one 32-bit value by the 3-bit selector, and scans it as 8 hex digits on the multiplexed 7-segment display.
- Sits beside the CPU top level. Inputs come from pipeline status strobes; outputs drive the board anodes/segments.

---
 rtl/stat_pkg.sv | 25 ++
 rtl/stat_display_hex7seg.sv | 11 +
 rtl/stat_display.sv | 142 ++++++++++++++
 tb/tb_stat_display.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stat_pkg.sv
// Shared encodings and constants for the statistics display.
package stat_pkg;

    // Board switch selector encodings
    typedef enum logic [2:0] {
        SEL_BLANK = 3'b000,
        SEL_PC    = 3'b001,
        SEL_CYC   = 3'b010,
        SEL_JMP   = 3'b011,
        SEL_TAKEN = 3'b100,
        SEL_CBR   = 3'b101,
        SEL_MEM   = 3'b110,
        SEL_RSV   = 3'b111
    } sel_e;

    // All segments and the decimal point dark (active-low)
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/stat_display_hex7seg.sv
// Combinational nibble to active-low seven-segment glyph.
module hex7seg
    import stat_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph
);

    assign glyph = HEX_GLYPH[nib];

endmodule

// File: rtl/stat_display.sv
// CPU run statistics counters with a scanned 8-digit hex display.
module stat_display
    import stat_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disp_en,
    input  logic [2:0]  sel,
    input  logic [11:0] in_addr,
    input  logic [31:0] pc,
    input  logic        halt,
    input  logic        retire,
    input  logic        is_jmp,
    input  logic        is_cbr,
    input  logic        cbr_taken,
    output logic [11:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] cyc_q, cyc_d, jmp_q, jmp_d, cbr_q, cbr_d, taken_q, taken_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      snap_q, snap_d;
    logic             blank_q, blank_d;
    logic [11:0]      mem_addr_q, mem_addr_d;
    logic [7:0]       an_q, an_d, seg_q, seg_d;

    sel_e             sel_s;
    logic [31:0]      sel_val;
    logic             tc, frame_end;
    logic [3:0]       nib;
    logic [6:0]       glyph;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign sel_s = sel_e'(sel);

    // Statistics counters: frozen while halted, saturate at all-ones
    always_comb begin
        cyc_d   = cyc_q;
        jmp_d   = jmp_q;
        cbr_d   = cbr_q;
        taken_d = taken_q;
        if (!halt) begin
            cyc_d = sat_inc(cyc_q);
            if (retire) begin
                if (is_jmp) jmp_d = sat_inc(jmp_q);
                if (is_cbr) begin
                    cbr_d = sat_inc(cbr_q);
                    if (cbr_taken) taken_d = sat_inc(taken_q);
                end
            end
        end
    end

    // Value selected by the switches, sampled into the snapshot once per frame
    always_comb begin
        sel_val = '0;
        case (sel_s)
            SEL_PC:    sel_val = pc;
            SEL_CYC:   sel_val = 32'(cyc_q);
            SEL_JMP:   sel_val = 32'(jmp_q);
            SEL_TAKEN: sel_val = 32'(taken_q);
            SEL_CBR:   sel_val = 32'(cbr_q);
            SEL_MEM:   sel_val = mem_rdata;
            default:   sel_val = '0;
        endcase
    end

    // Scan divider, digit index and frame-boundary snapshot; the blank flag
    // is latched with the snapshot and resets to "not blank" so zeros show
    // until the first frame completes
    always_comb begin
        tc         = (div_q == DIV_W'(SCAN_DIV - 1));
        frame_end  = tc && (idx_q == 3'd7);
        div_d      = tc ? '0 : div_q + DIV_W'(1);
        idx_d      = tc ? idx_q + 3'd1 : idx_q;
        snap_d     = frame_end ? sel_val : snap_q;
        blank_d    = frame_end ? (sel_s == SEL_BLANK || sel_s == SEL_RSV) : blank_q;
        mem_addr_d = (sel_s == SEL_MEM) ? in_addr : mem_addr_q;
    end

    assign nib = snap_q[{idx_q, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nib   (nib),
        .glyph (glyph)
    );

    // Registered anode/segment drive, one cycle behind the digit index
    always_comb begin
        an_d  = 8'hFF;
        seg_d = SEG_OFF;
        if (disp_en && !blank_q) begin
            an_d  = ~(8'h01 << idx_q);
            seg_d = {1'b1, glyph};
        end
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_q      <= '0;
            jmp_q      <= '0;
            cbr_q      <= '0;
            taken_q    <= '0;
            div_q      <= '0;
            idx_q      <= '0;
            snap_q     <= '0;
            blank_q    <= 1'b0;
            mem_addr_q <= '0;
            an_q       <= 8'hFF;
            seg_q      <= SEG_OFF;
        end else begin
            cyc_q      <= cyc_d;
            jmp_q      <= jmp_d;
            cbr_q      <= cbr_d;
            taken_q    <= taken_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            blank_q    <= blank_d;
            mem_addr_q <= mem_addr_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign an       = an_q;
    assign seg      = seg_q;

endmodule

// File: tb/tb_stat_display.sv
// Randomized scoreboard bench for stat_display (full-width and 4-bit counter builds).
module tb_stat_display;

    localparam int SD = 4;
    localparam int FR = 8 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, disp_en = 1'b0, halt = 1'b0;
    logic        retire = 1'b0, is_jmp = 1'b0, is_cbr = 1'b0, cbr_taken = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [11:0] in_addr = '0;
    logic [31:0] pc = 32'h1234_5678;
    logic [31:0] mem_rdata = '0;
    logic [11:0] mem_addr, mem_addr4;
    logic [7:0]  an, seg, an4, seg4;

    always #5 clk = ~clk;

    stat_display #(.SCAN_DIV(SD), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .sel(sel), .in_addr(in_addr),
        .pc(pc), .halt(halt), .retire(retire), .is_jmp(is_jmp), .is_cbr(is_cbr),
        .cbr_taken(cbr_taken), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .an(an), .seg(seg)
    );

    stat_display #(.SCAN_DIV(SD), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .sel(sel), .in_addr(in_addr),
        .pc(pc), .halt(halt), .retire(retire), .is_jmp(is_jmp), .is_cbr(is_cbr),
        .cbr_taken(cbr_taken), .mem_addr(mem_addr4), .mem_rdata(mem_rdata),
        .an(an4), .seg(seg4)
    );

    // Data-memory debug port: read data one cycle after the address
    always @(posedge clk)
        mem_rdata <= (mem_addr == 12'h0A5) ? 32'hDEADBEEF : {mem_addr, ~mem_addr, 8'h5A};

    always @(posedge clk)
        if (rst_n && retire) assert (!(is_jmp && is_cbr)) else $error("illegal is_jmp and is_cbr together");

    // Reference model: true event counts, saturation applied when shown
    typedef struct { logic [7:0] an; logic [7:0] seg; logic [7:0] seg4; logic [11:0] maddr; } exp_t;
    exp_t q[$];

    logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    longint unsigned n_cyc = 0, n_jmp = 0, n_cbr = 0, n_tak = 0;
    int          pos = 0;
    logic [31:0] snap = '0, snap4 = '0;
    bit          lblank = 1'b0;
    logic [11:0] maddr = '0;

    function automatic logic [31:0] capped(longint unsigned n, int w);
        longint unsigned mx = (64'd1 << w) - 1;
        return 32'(n > mx ? mx : n);
    endfunction

    function automatic logic [31:0] value_of(logic [2:0] s, int w);
        case (s)
            3'd1: return pc;
            3'd2: return capped(n_cyc, w);
            3'd3: return capped(n_jmp, w);
            3'd4: return capped(n_tak, w);
            3'd5: return capped(n_cbr, w);
            3'd6: return mem_rdata;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [7:0] show(logic [31:0] v, int d);
        logic [3:0] n;
        n = v[d*4 +: 4];
        return glyph[n];
    endfunction

    always @(posedge clk) begin : model
        exp_t e;
        int   d;
        if (!rst_n) begin
            n_cyc = 0; n_jmp = 0; n_cbr = 0; n_tak = 0;
            pos = 0; snap = '0; snap4 = '0; lblank = 1'b0; maddr = '0;
            e = '{8'hFF, 8'hFF, 8'hFF, 12'h000};
        end else begin
            d = pos / SD;
            if (!disp_en || lblank) begin
                e.an = 8'hFF; e.seg = 8'hFF; e.seg4 = 8'hFF;
            end else begin
                e.an = ~(8'h01 << d); e.seg = show(snap, d); e.seg4 = show(snap4, d);
            end
            if (pos == FR - 1) begin
                snap   = value_of(sel, 32);
                snap4  = value_of(sel, 4);
                lblank = (sel == 3'd0 || sel == 3'd7);
            end
            pos = (pos + 1) % FR;
            if (sel == 3'd6) maddr = in_addr;
            e.maddr = maddr;
            if (!halt) begin
                n_cyc++;
                if (retire) begin
                    if (is_jmp) n_jmp++;
                    if (is_cbr) begin
                        n_cbr++;
                        if (cbr_taken) n_tak++;
                    end
                end
            end
        end
        q.push_back(e);
    end

    int errs = 0, checks = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares each registered output cycle against the queued expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("an",        32'(an),        32'(e.an));
            check("seg",       32'(seg),       32'(e.seg));
            check("mem_addr",  32'(mem_addr),  32'(e.maddr));
            check("an_w4",     32'(an4),       32'(e.an));
            check("seg_w4",    32'(seg4),      32'(e.seg4));
            check("mem_addr4", 32'(mem_addr4), 32'(e.maddr));
        end
    end

    task automatic run(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(bit j, bit c, bit t);
        @(negedge clk);
        retire = 1'b1; is_jmp = j; is_cbr = c; cbr_taken = t;
        @(negedge clk);
        retire = 1'b0; is_jmp = 1'b0; is_cbr = 1'b0; cbr_taken = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1; sel = 3'd2; disp_en = 1'b1;
        run(80);

        // Branch statistics, each selector shown after a frame
        repeat (5) pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b1);
        sel = 3'd3; run(72);
        sel = 3'd5; run(72);
        sel = 3'd4; run(72);
        sel = 3'd1; run(72);

        // Halt with retire activity: nothing may count
        sel = 3'd2; halt = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            retire = ~retire; is_jmp = i[1]; is_cbr = ~i[1]; cbr_taken = 1'b1;
        end
        retire = 1'b0; is_jmp = 1'b0; is_cbr = 1'b0; halt = 1'b0;
        run(40);

        // Memory word view
        sel = 3'd6; in_addr = 12'h0A5;
        run(72);

        // Blanking by switch and by selector
        disp_en = 1'b0; run(40);
        disp_en = 1'b1; sel = 3'd0; run(72);
        sel = 3'd7; run(72);

        // Randomized traffic
        for (int i = 0; i < 480; i++) begin
            @(negedge clk);
            r = $urandom;
            retire    = r[0];
            is_jmp    = (r[2:1] == 2'd1);
            is_cbr    = r[2];
            cbr_taken = r[3];
            halt      = (r[7:4] == 4'd0);
            disp_en   = (r[11:8] != 4'd0);
            pc        = $urandom;
            in_addr   = 12'($urandom);
            if (i % 40 == 0) sel = 3'($urandom_range(0, 7));
        end
        retire = 1'b0; is_jmp = 1'b0; is_cbr = 1'b0; halt = 1'b0; disp_en = 1'b1;

        // Reset mid-frame, then recover
        sel = 3'd2;
        run(13);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(80);

        run(2);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
